// File: rtl/seg7_mux_counter_if.sv
// Bus bundle for seg7_mux_counter: control/load inputs plus count and display outputs.
// The master modport is the controlling side; the slave modport is the counter itself.
interface seg7_mux_counter_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  en;
   logic                  up_dn;
   logic                  clear;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count_out;
   logic                  wrap;
   logic [7:0]            seg_out;
   logic [DIGITS-1:0]     dig_sel;

   modport master (
      output en, up_dn, clear, load, load_val,
      input  count_out, wrap, seg_out, dig_sel
   );

   modport slave (
      input  en, up_dn, clear, load, load_val,
      output count_out, wrap, seg_out, dig_sel
   );
endinterface

// File: rtl/seg7_mux_counter.sv
// Multi-digit hex/BCD up/down counter with prescaled stepping, driving a time-multiplexed
// common-anode 7-segment display with one blank cycle on every digit switch.
module seg7_mux_counter #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned PRESCALE_W = 25,
   parameter int unsigned SCAN_W     = 16,
   parameter bit          BCD        = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   seg7_mux_counter_if.slave bus
);

   localparam int unsigned        IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IdxW-1:0]    LastIdx = IdxW'(DIGITS - 1);
   localparam logic [3:0]         DigMax  = BCD ? 4'd9 : 4'd15;
   localparam logic [DIGITS-1:0]  OneHot0 = DIGITS'(1);

   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [SCAN_W-1:0]     scan_q, scan_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [4*DIGITS-1:0]   count_q, count_d;
   logic                  wrap_q, wrap_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;

   logic                  tick;
   logic                  scan_tick;
   logic [4*DIGITS-1:0]   step_val;
   logic                  step_carry;
   logic [4*DIGITS-1:0]   load_clamped;
   logic [3:0]            cur_nib;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b0000001;
         4'h1:    pat = 7'b1001111;
         4'h2:    pat = 7'b0010010;
         4'h3:    pat = 7'b0000110;
         4'h4:    pat = 7'b1001100;
         4'h5:    pat = 7'b0100100;
         4'h6:    pat = 7'b0100000;
         4'h7:    pat = 7'b0001111;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0000100;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b1100000;
         4'hC:    pat = 7'b1110010;
         4'hD:    pat = 7'b1000010;
         4'hE:    pat = 7'b0110000;
         default: pat = 7'b0111000;
      endcase
      return pat;
   endfunction

   assign tick      = &presc_q;
   assign scan_tick = &scan_q;

   // Ripple carry/borrow: the step enters digit 0 and propagates while digits roll over.
   always_comb begin
      step_val   = count_q;
      step_carry = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (step_carry) begin
            if (bus.up_dn) begin
               if (count_q[4*i +: 4] >= DigMax) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  step_carry         = 1'b0;
               end
            end else begin
               if (count_q[4*i +: 4] == 4'd0) begin
                  step_val[4*i +: 4] = DigMax;
               end else begin
                  step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                  step_carry         = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      load_clamped = bus.load_val;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bus.load_val[4*i +: 4] > DigMax) begin
            load_clamped[4*i +: 4] = DigMax;
         end
      end
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.clear) begin
         count_d = '0;
      end else if (bus.load) begin
         count_d = load_clamped;
      end else if (tick && bus.en) begin
         count_d = step_val;
         wrap_d  = step_carry;
      end
   end

   // With a single digit LastIdx is 0, so the index never changes and never blanks.
   always_comb begin
      scan_d = scan_q + 1'b1;
      idx_d  = idx_q;
      if (scan_tick) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
      dig_sel_d = ~(OneHot0 << idx_d);
   end

   always_comb begin
      cur_nib = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            cur_nib = count_q[4*i +: 4];
         end
      end
      seg_d = {seg_decode(cur_nib), ~((idx_q == '0) && !bus.en)};
      if (idx_d != idx_q) begin
         seg_d = 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         scan_q    <= '0;
         idx_q     <= '0;
         count_q   <= '0;
         wrap_q    <= 1'b0;
         seg_q     <= 8'hFF;
         dig_sel_q <= '1;
      end else begin
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         seg_q     <= seg_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   assign bus.count_out = count_q;
   assign bus.wrap      = wrap_q;
   assign bus.seg_out   = seg_q;
   assign bus.dig_sel   = dig_sel_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// Directed bench for seg7_mux_counter: hex and BCD two-digit builds plus a one-digit build,
// all with a 4-clock prescaler and scan period, sharing clock and reset.
module tb_seg7_mux_counter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   cyc;
   int   wrap_seen;

   seg7_mux_counter_if #(.DIGITS(2)) hex_if ();
   seg7_mux_counter_if #(.DIGITS(2)) bcd_if ();
   seg7_mux_counter_if #(.DIGITS(1)) one_if ();

   seg7_mux_counter #(.DIGITS(2), .PRESCALE_W(2), .SCAN_W(2), .BCD(1'b0)) u_hex (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hex_if)
   );

   seg7_mux_counter #(.DIGITS(2), .PRESCALE_W(2), .SCAN_W(2), .BCD(1'b1)) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bcd_if)
   );

   seg7_mux_counter #(.DIGITS(1), .PRESCALE_W(2), .SCAN_W(2), .BCD(1'b0)) u_one (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (one_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick_clk();
   endtask

   // Called between edges; checks the asynchronous reset state before any edge arrives.
   task automatic do_reset();
      rst_n = 1'b0;
      hex_if.en = 1'b0; hex_if.up_dn = 1'b1; hex_if.clear = 1'b0; hex_if.load = 1'b0;
      hex_if.load_val = '0;
      bcd_if.en = 1'b0; bcd_if.up_dn = 1'b1; bcd_if.clear = 1'b0; bcd_if.load = 1'b0;
      bcd_if.load_val = '0;
      one_if.en = 1'b0; one_if.up_dn = 1'b1; one_if.clear = 1'b0; one_if.load = 1'b0;
      one_if.load_val = '0;
      #1;
      check_eq("rst count", hex_if.count_out, 32'h0);
      check_eq("rst wrap", hex_if.wrap, 32'h0);
      check_eq("rst seg", hex_if.seg_out, 32'hFF);
      check_eq("rst dig_sel", hex_if.dig_sel, 32'h3);
      check_eq("rst one dig_sel", one_if.dig_sel, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   function automatic logic [7:0] scan_seg_exp(input int k, input bit dp_lit);
      if (k % 4 == 0) return 8'hFF;
      if ((k / 4) % 2 == 0) return dp_lit ? 8'h10 : 8'h11;
      return 8'h0D;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      cyc       = 0;
      wrap_seen = 0;
      rst_n     = 1'b1;
      #1;

      // Free-running hex up count through a full wrap.
      do_reset();
      hex_if.en    = 1'b1;
      hex_if.up_dn = 1'b1;
      for (int k = 1; k <= 1024; k++) begin
         tick_clk();
         check_eq($sformatf("t1 count k=%0d", k), hex_if.count_out, 32'((k / 4) % 256));
         check_eq($sformatf("t1 wrap k=%0d", k), hex_if.wrap,
                  32'((k % 4 == 0) && ((k / 4) % 256 == 0)));
         if (hex_if.wrap) wrap_seen++;
      end
      check_eq("t1 wrap total", wrap_seen, 32'd1);

      // BCD stepping, wrap both ways, load clamping and cross-digit borrow.
      #2;
      do_reset();
      bcd_if.load = 1'b1; bcd_if.load_val = 8'h98; bcd_if.en = 1'b1; bcd_if.up_dn = 1'b1;
      run_to(1);
      check_eq("t2 load 98", bcd_if.count_out, 32'h98);
      bcd_if.load = 1'b0;
      run_to(4);
      check_eq("t2 up 99", bcd_if.count_out, 32'h99);
      check_eq("t2 no wrap 99", bcd_if.wrap, 32'h0);
      run_to(8);
      check_eq("t2 up 00", bcd_if.count_out, 32'h00);
      check_eq("t2 wrap up", bcd_if.wrap, 32'h1);
      run_to(9);
      check_eq("t2 wrap one clk", bcd_if.wrap, 32'h0);
      bcd_if.up_dn = 1'b0;
      run_to(12);
      check_eq("t2 down 99", bcd_if.count_out, 32'h99);
      check_eq("t2 wrap down", bcd_if.wrap, 32'h1);
      bcd_if.load = 1'b1; bcd_if.load_val = 8'hAF;
      run_to(13);
      check_eq("t2 clamp AF", bcd_if.count_out, 32'h99);
      check_eq("t2 load no wrap", bcd_if.wrap, 32'h0);
      bcd_if.load_val = 8'h10;
      run_to(14);
      check_eq("t2 load 10", bcd_if.count_out, 32'h10);
      bcd_if.load = 1'b0;
      run_to(16);
      check_eq("t2 borrow 09", bcd_if.count_out, 32'h09);
      check_eq("t2 borrow no wrap", bcd_if.wrap, 32'h0);

      // Clear/load priority over a coincident step; hex down-wrap from zero.
      #2;
      do_reset();
      hex_if.load = 1'b1; hex_if.load_val = 8'h55;
      run_to(1);
      check_eq("t3 load 55", hex_if.count_out, 32'h55);
      hex_if.load = 1'b0;
      run_to(3);
      check_eq("t3 hold 55", hex_if.count_out, 32'h55);
      hex_if.clear = 1'b1; hex_if.load = 1'b1; hex_if.load_val = 8'hAA; hex_if.en = 1'b1;
      run_to(4);
      check_eq("t3 clear wins", hex_if.count_out, 32'h00);
      check_eq("t3 clear no wrap", hex_if.wrap, 32'h0);
      hex_if.clear = 1'b0; hex_if.load = 1'b0;
      run_to(7);
      check_eq("t3 no tick", hex_if.count_out, 32'h00);
      hex_if.load = 1'b1; hex_if.load_val = 8'h3C;
      run_to(8);
      check_eq("t3 load over step", hex_if.count_out, 32'h3C);
      hex_if.load = 1'b0;
      run_to(12);
      check_eq("t3 step 3D", hex_if.count_out, 32'h3D);
      hex_if.clear = 1'b1;
      run_to(13);
      check_eq("t3 clear", hex_if.count_out, 32'h00);
      hex_if.clear = 1'b0; hex_if.up_dn = 1'b0;
      run_to(16);
      check_eq("t3 down FF", hex_if.count_out, 32'hFF);
      check_eq("t3 down wrap", hex_if.wrap, 32'h1);
      hex_if.load = 1'b1; hex_if.load_val = 8'hAF;
      run_to(17);
      check_eq("t3 hex load AF", hex_if.count_out, 32'hAF);
      hex_if.load = 1'b0;

      // Scan with count held at 3A, then paused (dp on digit 0), then running again.
      #2;
      do_reset();
      hex_if.load = 1'b1; hex_if.load_val = 8'h3A; hex_if.en = 1'b1;
      for (int k = 2; k <= 17; k++) begin
         run_to(k);
         check_eq($sformatf("t4 seg k=%0d", k), hex_if.seg_out, 32'(scan_seg_exp(k, 1'b0)));
         check_eq($sformatf("t4 dig k=%0d", k), hex_if.dig_sel,
                  ((k / 4) % 2 == 0) ? 32'h2 : 32'h1);
      end
      hex_if.load = 1'b0; hex_if.en = 1'b0;
      for (int k = 18; k <= 33; k++) begin
         run_to(k);
         check_eq($sformatf("t5 seg k=%0d", k), hex_if.seg_out, 32'(scan_seg_exp(k, 1'b1)));
      end
      check_eq("t5 count held", hex_if.count_out, 32'h3A);
      hex_if.load = 1'b1; hex_if.en = 1'b1;
      for (int k = 34; k <= 41; k++) begin
         run_to(k);
         check_eq($sformatf("t5 dp off k=%0d", k), hex_if.seg_out,
                  32'(scan_seg_exp(k, 1'b0)));
      end

      // Single digit: constant strobe, never blanked.
      #2;
      do_reset();
      one_if.load = 1'b1; one_if.load_val = 4'h7; one_if.en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         run_to(k);
         check_eq($sformatf("t6 one dig k=%0d", k), one_if.dig_sel, 32'h0);
         check_eq($sformatf("t6 one seg k=%0d", k), one_if.seg_out, (k == 1) ? 32'h03 : 32'h1F);
      end

      // Asynchronous reset mid-count, then first step 4 clks after release.
      #2;
      do_reset();
      hex_if.en = 1'b1; hex_if.up_dn = 1'b1;
      run_to(10);
      check_eq("t6 pre-reset count", hex_if.count_out, 32'h02);
      #2;
      do_reset();
      hex_if.en = 1'b1; hex_if.up_dn = 1'b1;
      run_to(3);
      check_eq("t6 no early step", hex_if.count_out, 32'h00);
      run_to(4);
      check_eq("t6 first step", hex_if.count_out, 32'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
